mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
//  Multi-cycle control FSM that sequences the shared MIPS datapath (PC, IR, register file, ALU, DM)
//  through FETCH/DECODE/EXEC/MEM/WB steps, one instruction at a time.
//  Replaces the single-cycle combinational decoder. Drives every datapath mux select and write
//  enable, and keeps a retired-instruction counter.
// PARAMETERS
//  CNT_W            32  width of retired-instruction counter
//  HALT_ON_ILLEGAL  1   1: illegal op -> HALT (sticky); 0: illegal op retires as NOP
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-low reset
//  opcode       in   6      IR[31:26], valid from DECODE onward
//  funct        in   6      IR[5:0]
//  zero         in   1      ALU zero flag
//  mem_ready    in   1      memory ack (used only with MC_MEM_WAIT_EN)
//  pc_write     out  1      PC load enable
//  pc_src       out  2      0 ALU result (PC+4), 1 branch target reg, 2 jump {PC[31:28],imm26,2'b0}
//  ir_write     out  1      IR load enable
//  reg_dst      out  1      0 rt, 1 rd
//  mem_to_reg   out  1      0 ALUOut, 1 MDR
//  reg_write    out  1      register-file write enable
//  mem_read     out  1      memory read strobe (IM in FETCH, DM in MEM_RD)
//  mem_write    out  1      DM write enable
//  alu_src_a    out  1      0 PC, 1 rs
//  alu_src_b    out  2      0 rt, 1 const 4, 2 ext_imm, 3 ext_imm<<2
//  alu_op       out  3      mc_pkg ALU_* code
//  ext_op       out  1      0 zero-extend, 1 sign-extend
//  illegal      out  1      sticky undecodable-instruction flag
//  instr_cnt    out  CNT_W  retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (rst=0): state=IDLE, all outputs 0, instr_cnt=0, illegal=0. Async assert, sync release.
//  - Mid-operation reset aborts the instruction; no write enable may be high while rst=0.
//  - Outputs are Moore-decoded from state. Exception: pc_write in BRANCH = zero.
//  - IDLE -> FETCH unconditionally (one cycle after reset release).
//  - FETCH: mem_read, ir_write, pc_write, src_a=PC, src_b=4, ALU_ADD -> DECODE.
//  - DECODE: src_a=PC, src_b=3, ALU_ADD, ext_op=1 (precompute branch target).
//    Dispatch by opcode:
//      000000 -> EXEC_R if funct in {100001 addu, 100011 subu, 101010 slt}, else ILL
//      100011 lw / 101011 sw -> MEM_ADDR
//      000100 beq -> BRANCH
//      000010 j -> JUMP
//      001101 ori -> EXEC_I (ALU_OR, ext_op=0)
//      001111 lui -> EXEC_I (ALU_LUI)
//      other -> ILL
//  - EXEC_R: src_a=1, src_b=0, alu_op from funct -> WB_R (reg_dst=1, reg_write) -> FETCH.
//  - EXEC_I: src_a=1, src_b=2 -> WB_I (reg_dst=0, reg_write) -> FETCH.
//  - MEM_ADDR: src_a=1, src_b=2, ext_op=1, ALU_ADD -> MEM_RD (lw) | MEM_WR (sw).
//  - MEM_RD: mem_read -> WB_MEM (mem_to_reg=1, reg_dst=0, reg_write) -> FETCH.
//  - MEM_WR: mem_write -> FETCH.
//  - BRANCH: src_a=1, src_b=0, ALU_SUB, pc_src=1, pc_write=zero -> FETCH.
//  - JUMP: pc_src=2, pc_write -> FETCH.
//  - ILL: illegal<=1. HALT_ON_ILLEGAL=1 -> HALT (no enables, absorbing until reset);
//    HALT_ON_ILLEGAL=0 -> FETCH, counts as retired.
//  - Latency (no wait): beq/j 3 cycles; R/I/sw 4 cycles; lw 5 cycles.
//  - instr_cnt +1 on the cycle leaving a terminal state into FETCH; 2^CNT_W-1 wraps to 0.
//  - opcode/funct are sampled only in DECODE and EXEC_R; changes in other states are ignored.
// CONFIGURATION
//  - MC_MEM_WAIT_EN defined:
//    FETCH, MEM_RD and MEM_WR hold (outputs steady) until mem_ready=1.
//    pc_write/ir_write/mem_write assert only on the mem_ready cycle.
//  - Not defined: mem_ready ignored; each memory state lasts exactly 1 cycle.
// STRUCTURE
//  - mc_pkg: state enum (4-bit), ALU_ADD=0 SUB=1 OR=2 AND=3 SLT=4 LUI=5,
//    OP_* and FN_* opcode/funct constants, pc_src and alu_src_b encodings.
//  - Sub-module mc_alu_dec: combinational funct -> alu_op, plus valid flag for EXEC_R.
//  - Top: state register + next-state logic + Moore output decode + counter.
// TESTING
//  1. rst=0 pulse mid-MEM_WR -> mem_write drops immediately; next after release: IDLE, FETCH.
//     instr_cnt=0.
//  2. addu (op 0, funct 0x21) -> FETCH,DECODE,EXEC_R,WB_R;
//     reg_write=1, reg_dst=1 in cycle 4 only; instr_cnt=1.
//  3. lw then sw -> 5 then 4 cycles; mem_to_reg=1 only in WB_MEM;
//     mem_write=1 for exactly 1 cycle; instr_cnt=2.
//  4. beq with zero=1 then zero=0 -> pc_write=1 / 0 in BRANCH with pc_src=1;
//     j -> pc_src=2, pc_write=1.
//  5. opcode 0x3F, HALT_ON_ILLEGAL=1 -> illegal=1, HALT, no enables for 20 cycles;
//     with HALT_ON_ILLEGAL=0 -> back to FETCH, instr_cnt+1.
//  6. MC_MEM_WAIT_EN, mem_ready low 3 cycles in FETCH -> ir_write/pc_write only on 4th cycle.
//     CNT_W=4: 16 retirements wrap instr_cnt to 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control slice: states, ALU codes,
// opcode/funct constants, datapath select encodings and the control bundle.
package mc_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_FETCH    = 4'd1;
  localparam state_t S_DECODE   = 4'd2;
  localparam state_t S_EXEC_R   = 4'd3;
  localparam state_t S_WB_R     = 4'd4;
  localparam state_t S_EXEC_I   = 4'd5;
  localparam state_t S_WB_I     = 4'd6;
  localparam state_t S_MEM_ADDR = 4'd7;
  localparam state_t S_MEM_RD   = 4'd8;
  localparam state_t S_WB_MEM   = 4'd9;
  localparam state_t S_MEM_WR   = 4'd10;
  localparam state_t S_BRANCH   = 4'd11;
  localparam state_t S_JUMP     = 4'd12;
  localparam state_t S_ILL      = 4'd13;
  localparam state_t S_HALT     = 4'd14;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_LUI = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  localparam logic [1:0] PC_SRC_ALU = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_4      = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       ext_op;
  } ctrl_t;

endpackage

// File: rtl/mc_alu_dec.sv
// R-type funct decoder: ALU operation plus a flag saying the funct is supported.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (funct)
      FN_ADDU: alu_op = ALU_ADD;
      FN_SUBU: alu_op = ALU_SUB;
      FN_SLT:  alu_op = ALU_SLT;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with retired-instruction counter.
// Define MC_MEM_WAIT_EN to stall FETCH/MEM_RD/MEM_WR until mem_ready.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W           = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             ext_op,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t           state_q, state_d;
  logic             is_lw_q, is_lw_d;
  logic             is_lui_q, is_lui_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             mem_go;
  logic [2:0]       fn_op;
  logic             fn_vld;
  ctrl_t            ctl;

`ifdef MC_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  // mem_ready has no effect in this build
  assign mem_go = 1'b1 | mem_ready;
`endif

  mc_alu_dec u_alu_dec (
    .funct  (funct),
    .alu_op (fn_op),
    .valid  (fn_vld)
  );

  always_comb begin
    state_d   = state_q;
    is_lw_d   = is_lw_q;
    is_lui_d  = is_lui_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (mem_go) state_d = S_DECODE;
      S_DECODE: begin
        // opcode is only guaranteed stable here, so remember what later states need
        is_lw_d  = (opcode == OP_LW);
        is_lui_d = (opcode == OP_LUI);
        case (opcode)
          OP_RTYPE:     state_d = fn_vld ? S_EXEC_R : S_ILL;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ORI,
          OP_LUI:       state_d = S_EXEC_I;
          default:      state_d = S_ILL;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = is_lw_q ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_go) state_d = S_WB_MEM;
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEM_WR: if (mem_go) begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ILL: begin
        illegal_d = 1'b1;
        if (HALT_ON_ILLEGAL) state_d = S_HALT;
        else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.ir_write  = mem_go;
        ctl.pc_write  = mem_go;
        ctl.alu_src_b = SRCB_4;
        ctl.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        ctl.alu_src_b = SRCB_IMM_SH;
        ctl.alu_op    = ALU_ADD;
        ctl.ext_op    = 1'b1;
      end
      S_EXEC_R: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_RT;
        ctl.alu_op    = fn_op;
      end
      S_EXEC_I: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = is_lui_q ? ALU_LUI : ALU_OR;
      end
      S_WB_R: begin
        ctl.reg_dst   = 1'b1;
        ctl.reg_write = 1'b1;
      end
      S_WB_I: ctl.reg_write = 1'b1;
      S_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_ADD;
        ctl.ext_op    = 1'b1;
      end
      S_MEM_RD: ctl.mem_read = 1'b1;
      S_WB_MEM: begin
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
      end
      S_MEM_WR: ctl.mem_write = mem_go;
      S_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_RT;
        ctl.alu_op    = ALU_SUB;
        ctl.pc_src    = PC_SRC_BR;
        ctl.pc_write  = zero;
      end
      S_JUMP: begin
        ctl.pc_src   = PC_SRC_JMP;
        ctl.pc_write = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      is_lw_q   <= 1'b0;
      is_lui_q  <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      is_lw_q   <= is_lw_d;
      is_lui_q  <= is_lui_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pc_write   = ctl.pc_write;
  assign pc_src     = ctl.pc_src;
  assign ir_write   = ctl.ir_write;
  assign reg_dst    = ctl.reg_dst;
  assign mem_to_reg = ctl.mem_to_reg;
  assign reg_write  = ctl.reg_write;
  assign mem_read   = ctl.mem_read;
  assign mem_write  = ctl.mem_write;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign alu_op     = ctl.alu_op;
  assign ext_op     = ctl.ext_op;
  assign illegal    = illegal_q;
  assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: two instances (halting / non-halting, 32b / 4b counter)
// checked every cycle against an instruction-level table of expected control steps.
module tb_mc_ctrl;

`ifdef MC_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam int K_R = 0, K_ORI = 1, K_LUI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5, K_J = 6, K_ILL = 7;
  localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_OR = 3'd2, A_SLT = 3'd4, A_LUI = 3'd5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;

  always #5 clk = ~clk;

  logic a_pw, a_irw, a_rd, a_m2r, a_rw, a_mr, a_mw, a_sa, a_ext, a_ill;
  logic [1:0] a_ps, a_sb;
  logic [2:0] a_op;
  logic [31:0] a_cnt;
  logic b_pw, b_irw, b_rd, b_m2r, b_rw, b_mr, b_mw, b_sa, b_ext, b_ill;
  logic [1:0] b_ps, b_sb;
  logic [2:0] b_op;
  logic [3:0] b_cnt;

  mc_ctrl #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b1)) u_a (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(a_pw), .pc_src(a_ps), .ir_write(a_irw), .reg_dst(a_rd), .mem_to_reg(a_m2r),
    .reg_write(a_rw), .mem_read(a_mr), .mem_write(a_mw), .alu_src_a(a_sa), .alu_src_b(a_sb),
    .alu_op(a_op), .ext_op(a_ext), .illegal(a_ill), .instr_cnt(a_cnt));

  mc_ctrl #(.CNT_W(4), .HALT_ON_ILLEGAL(1'b0)) u_b (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(b_pw), .pc_src(b_ps), .ir_write(b_irw), .reg_dst(b_rd), .mem_to_reg(b_m2r),
    .reg_write(b_rw), .mem_read(b_mr), .mem_write(b_mw), .alu_src_a(b_sa), .alu_src_b(b_sb),
    .alu_op(b_op), .ext_op(b_ext), .illegal(b_ill), .instr_cnt(b_cnt));

  int n_chk = 0, n_fail = 0;
  int cnt_a = 0, cnt_b = 0;
  bit ill_a = 0, ill_b = 0, halt_a = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(bit pw, logic [1:0] ps, bit irw, bit rd, bit m2r, bit rw,
                                     bit mr, bit mw, bit sa, logic [1:0] sb, logic [2:0] op, bit ext);
    return {pw, ps, irw, rd, m2r, rw, mr, mw, sa, sb, op, ext};
  endfunction

  function automatic int n_steps(int k);
    if (k == K_BEQ || k == K_J || k == K_ILL) return 3;
    if (k == K_LW) return 5;
    return 4;
  endfunction

  function automatic bit mem_step(int k, int idx);
    return idx == 0 || (idx == 3 && (k == K_LW || k == K_SW));
  endfunction

  // expected control word for step idx of an instruction of kind k
  function automatic logic [15:0] exp_vec(int k, int idx, logic [5:0] fn, bit z, bit go);
    logic [2:0] rop;
    rop = (fn == 6'h23) ? A_SUB : (fn == 6'h2a) ? A_SLT : A_ADD;
    if (idx == 0) return mk(go, 0, go, 0, 0, 0, 1, 0, 0, 2'd1, A_ADD, 0);
    if (idx == 1) return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, A_ADD, 1);
    case (k)
      K_R:   return (idx == 2) ? mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, rop, 0)
                               : mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 2'd0, A_ADD, 0);
      K_ORI, K_LUI:
             return (idx == 2) ? mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, (k == K_ORI) ? A_OR : A_LUI, 0)
                               : mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, A_ADD, 0);
      K_LW:  return (idx == 2) ? mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, A_ADD, 1)
                  : (idx == 3) ? mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd0, A_ADD, 0)
                               : mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 2'd0, A_ADD, 0);
      K_SW:  return (idx == 2) ? mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, A_ADD, 1)
                               : mk(0, 0, 0, 0, 0, 0, 0, go, 0, 2'd0, A_ADD, 0);
      K_BEQ: return mk(z, 2'd1, 0, 0, 0, 0, 0, 0, 1, 2'd0, A_SUB, 0);
      K_J:   return mk(1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 2'd0, A_ADD, 0);
      default: return 16'h0;
    endcase
  endfunction

  task automatic check_state(input logic [15:0] ea, input logic [15:0] eb);
    chk("vec_a", {16'h0, a_pw, a_ps, a_irw, a_rd, a_m2r, a_rw, a_mr, a_mw, a_sa, a_sb, a_op, a_ext}, {16'h0, ea});
    chk("vec_b", {16'h0, b_pw, b_ps, b_irw, b_rd, b_m2r, b_rw, b_mr, b_mw, b_sa, b_sb, b_op, b_ext}, {16'h0, eb});
    chk("cnt_a", a_cnt, cnt_a);
    chk("cnt_b", {28'h0, b_cnt}, 32'(cnt_b % 16));
    chk("ill_a", {31'h0, a_ill}, {31'h0, ill_a});
    chk("ill_b", {31'h0, b_ill}, {31'h0, ill_b});
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    cnt_a = 0; cnt_b = 0; ill_a = 0; ill_b = 0; halt_a = 0;
    chk("rst_mw_a", {31'h0, a_mw}, 32'h0);
    chk("rst_mw_b", {31'h0, b_mw}, 32'h0);
    check_state(16'h0, 16'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_state(16'h0, 16'h0);
  endtask

  // zf: -1 random zero flag, else forced; abort_idx: step at which to pulse reset (-1 none)
  task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] fn,
                           input int zf, input int abort_idx);
    int  idx   = 0;
    int  holds = 0;
    bit  go, live;
    while (idx < n_steps(k)) begin
      @(negedge clk);
      live   = (idx == 1) || (idx == 2 && k == K_R);
      opcode = live ? op : 6'($urandom);
      funct  = live ? fn : 6'($urandom);
      zero   = (zf < 0) ? 1'($urandom) : zf[0];
      mem_ready = 1'($urandom);
      if (holds >= 3 || idx == abort_idx) mem_ready = 1'b1;
      go = WAIT_EN ? mem_ready : 1'b1;
      #1;
      check_state(halt_a ? 16'h0 : exp_vec(k, idx, fn, zero, go), exp_vec(k, idx, fn, zero, go));
      if (idx == abort_idx) begin
        do_reset();
        return;
      end
      if (mem_step(k, idx) && !go) holds++;
      else begin
        holds = 0;
        idx++;
      end
    end
    if (k == K_ILL) begin
      ill_a = 1'b1; ill_b = 1'b1; halt_a = 1'b1;
      cnt_b++;
    end else begin
      if (!halt_a) cnt_a++;
      cnt_b++;
    end
  endtask

  task automatic run_rand();
    int k;
    logic [5:0] op, fn;
    k  = $urandom_range(0, 6);
    fn = 6'($urandom);
    case (k)
      K_R: begin
        op = 6'h00;
        case ($urandom_range(0, 2))
          0: fn = 6'h21;
          1: fn = 6'h23;
          default: fn = 6'h2a;
        endcase
      end
      K_ORI: op = 6'h0d;
      K_LUI: op = 6'h0f;
      K_LW:  op = 6'h23;
      K_SW:  op = 6'h2b;
      K_BEQ: op = 6'h04;
      default: op = 6'h02;
    endcase
    run_instr(k, op, fn, -1, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    run_instr(K_R,   6'h00, 6'h21, -1, -1);
    run_instr(K_LW,  6'h23, 6'h00, -1, -1);
    run_instr(K_SW,  6'h2b, 6'h00, -1, -1);
    run_instr(K_BEQ, 6'h04, 6'h00, 1, -1);
    run_instr(K_BEQ, 6'h04, 6'h00, 0, -1);
    run_instr(K_J,   6'h02, 6'h00, -1, -1);
    run_instr(K_ORI, 6'h0d, 6'h00, -1, -1);
    run_instr(K_LUI, 6'h0f, 6'h00, -1, -1);
    run_instr(K_R,   6'h00, 6'h23, -1, -1);
    run_instr(K_SW,  6'h2b, 6'h00, -1, 3);
    for (int i = 0; i < 60; i++) run_rand();
    run_instr(K_ILL, 6'h3f, 6'h00, -1, -1);
    run_instr(K_R,   6'h00, 6'h21, -1, -1);
    run_instr(K_ILL, 6'h00, 6'h20, -1, -1);
    run_instr(K_LW,  6'h23, 6'h00, -1, -1);
    run_instr(K_SW,  6'h2b, 6'h00, -1, -1);
    run_instr(K_BEQ, 6'h04, 6'h00, 1, -1);
    run_instr(K_J,   6'h02, 6'h00, -1, -1);
    for (int i = 0; i < 12; i++) run_rand();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
